// File: rtl/port_io_scanner.sv
// rtl/port_io_scanner.sv - serial-bus scanner for remote port-I/O expanders
// Each frame: SYNC, then per port DIR / TURN / READ / WRITE over one shared bus.
module port_io_scanner #(
  parameter int NUM_PORTS   = 9,
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_en,
  input  logic [NUM_PORTS*WIDTH-1:0] port_w,
  input  logic [NUM_PORTS*WIDTH-1:0] port_d,
  output logic [NUM_PORTS*WIDTH-1:0] port_r,
  output logic [NUM_PORTS-1:0]       chg,
  input  logic [NUM_PORTS-1:0]       chg_clr,
  output logic                       scan_done,
  output logic                       port_clk,
  output logic                       port_rst,
  output logic [WIDTH-1:0]           bus_o,
  output logic                       bus_oe,
  input  logic [WIDTH-1:0]           bus_i
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PORTS - 1);
  localparam logic [3:0] TURN_LAST = 4'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, SYNC, DIR, TURN, READ, WRITE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic [3:0]       turn_cnt;
  logic [WIDTH-1:0] cur_w;
  logic [WIDTH-1:0] nxt_d;

  assign port_clk = clk;
  assign idx_nxt  = idx + 1'b1;

  // Outputs are registered, so the value for the state being entered is chosen here.
  always_comb begin
    cur_w = '0;
    nxt_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (idx == IW'(p))     cur_w = port_w[p*WIDTH +: WIDTH];
      if (idx_nxt == IW'(p)) nxt_d = port_d[p*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      turn_cnt  <= '0;
      port_r    <= '0;
      chg       <= '0;
      scan_done <= 1'b0;
      port_rst  <= 1'b0;
      bus_o     <= '0;
      bus_oe    <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      port_rst  <= 1'b0;
      bus_o     <= '0;
      bus_oe    <= 1'b0;
      chg       <= chg & ~chg_clr;
      case (state)
        IDLE: begin
          if (scan_en) begin
            state    <= SYNC;
            port_rst <= 1'b1;
            idx      <= '0;
          end
        end
        SYNC: begin
          state  <= DIR;
          idx    <= '0;
          bus_oe <= 1'b1;
          bus_o  <= port_d[WIDTH-1:0];
        end
        DIR: begin
          turn_cnt <= '0;
          state    <= (TURN_CYCLES == 0) ? READ : TURN;
        end
        TURN: begin
          turn_cnt <= turn_cnt + 1'b1;
          if (turn_cnt == TURN_LAST) state <= READ;
        end
        READ: begin
          // A set here lands after the clear above, so a same-cycle set wins.
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (idx == IW'(p)) begin
              port_r[p*WIDTH +: WIDTH] <= bus_i;
              if (bus_i != port_r[p*WIDTH +: WIDTH]) chg[p] <= 1'b1;
            end
          end
          state  <= WRITE;
          bus_oe <= 1'b1;
          bus_o  <= cur_w;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            scan_done <= 1'b1;
            idx       <= '0;
            if (scan_en) begin
              state    <= SYNC;
              port_rst <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            idx    <= idx_nxt;
            state  <= DIR;
            bus_oe <= 1'b1;
            bus_o  <= nxt_d;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port_io_scanner.sv
// tb/tb_port_io_scanner.sv - scoreboard bench for port_io_scanner
// Frame results are queued at SYNC and checked at scan_done; bus is checked every cycle.
module tb_port_io_scanner;
  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [23:0] port_w, port_d, port_r;
  logic [2:0]  chg, chg_clr;
  logic        scan_done, port_clk, port_rst, bus_oe;
  logic [7:0]  bus_o, bus_i;

  logic        en9;
  logic [71:0] zero72 = '0;
  logic [8:0]  zero9 = '0;
  logic [7:0]  bus_i9 = 8'h77;
  logic [71:0] r9a, r9b;
  logic [8:0]  chg9a, chg9b;
  logic        sd9a, sd9b, pc9a, pc9b, pr9a, pr9b, oe9a, oe9b;
  logic [7:0]  bo9a, bo9b;

  always #5 clk = ~clk;

  port_io_scanner #(.NUM_PORTS(3), .WIDTH(8), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .port_w(port_w), .port_d(port_d),
    .port_r(port_r), .chg(chg), .chg_clr(chg_clr), .scan_done(scan_done),
    .port_clk(port_clk), .port_rst(port_rst), .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i));

  port_io_scanner #(.NUM_PORTS(9), .WIDTH(8), .TURN_CYCLES(0)) dut_t0 (
    .clk(clk), .rst(rst), .scan_en(en9), .port_w(zero72), .port_d(zero72),
    .port_r(r9a), .chg(chg9a), .chg_clr(zero9), .scan_done(sd9a),
    .port_clk(pc9a), .port_rst(pr9a), .bus_o(bo9a), .bus_oe(oe9a), .bus_i(bus_i9));

  port_io_scanner #(.NUM_PORTS(9), .WIDTH(8), .TURN_CYCLES(3)) dut_t3 (
    .clk(clk), .rst(rst), .scan_en(en9), .port_w(zero72), .port_d(zero72),
    .port_r(r9b), .chg(chg9b), .chg_clr(zero9), .scan_done(sd9b),
    .port_clk(pc9b), .port_rst(pr9b), .bus_o(bo9b), .bus_oe(oe9b), .bus_i(bus_i9));

  typedef struct {
    logic [23:0] r;
    logic [2:0]  c;
  } exp_t;

  exp_t        exp_q[$];
  int          q9a[$];
  int          q9b[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          dn9a = 0, dn9b = 0;
  int          s_frame = -1, s_cyc = 0;
  int          m_cyc = 0;
  bit          m_active = 1'b0;
  int          c9a = 0, c9b = 0;
  logic [23:0] rd_tab [6];
  logic [2:0]  chg_tab [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int f, input int c, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk); #1;
      if (s_frame == f && s_cyc == c) hit = 1'b1;
    end
    chk($sformatf("reach_f%0d_c%0d", f, c), 128'(hit), 128'(1));
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) begin
      @(negedge clk); #1;
    end
    chk($sformatf("done_cnt_%0d", n), 128'(done_cnt), 128'(n));
  endtask

  // Stimulus side: bus_i only carries the table value during READ; chg_clr by frame/cycle.
  always @(negedge clk) begin : tracker
    int p, ph;
    logic [23:0] row;
    if (!rst) begin
      s_cyc   = 0;
      chg_clr = 3'b000;
      bus_i   = 8'hEE;
    end else begin
      if (port_rst) begin
        s_frame++;
        s_cyc = 0;
        if (s_frame < 6) exp_q.push_back('{r: rd_tab[s_frame], c: chg_tab[s_frame]});
      end else begin
        s_cyc++;
      end
      p  = (s_cyc - 1) / 4;
      ph = (s_cyc - 1) % 4;
      bus_i = 8'hEE;
      if (s_cyc >= 1 && s_cyc <= 12 && ph == 2 && s_frame >= 0 && s_frame < 6) begin
        row   = rd_tab[s_frame];
        bus_i = row[p*8 +: 8];
      end
      chg_clr = 3'b000;
      if (s_frame == 2 && s_cyc == 0) chg_clr = 3'b010;
      if (s_frame == 2 && s_cyc == 3) chg_clr = 3'b001;
      if (s_frame == 3 && s_cyc == 0) chg_clr = 3'b111;
    end
  end

  always @(negedge clk) begin : monitor
    int p, ph;
    exp_t e;
    logic       exp_oe;
    logic [7:0] exp_o;
    if (!rst) begin
      m_active = 1'b0;
      m_cyc    = 0;
    end else begin
      if (scan_done) begin
        done_cnt++;
        chk("frame_len", 128'(m_cyc + 1), 128'(13));
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: scan_done with no expected frame");
        end else begin
          e = exp_q.pop_front();
          chk("port_r", 128'(port_r), 128'(e.r));
          chk("chg", 128'(chg), 128'(e.c));
        end
      end
      if (port_rst) begin
        m_active = 1'b1;
        m_cyc    = 0;
        chk("sync_bus", 128'({bus_oe, bus_o}), 128'(0));
      end else begin
        m_cyc++;
        if (m_active) begin
          p      = (m_cyc - 1) / 4;
          ph     = (m_cyc - 1) % 4;
          exp_oe = (ph == 0 || ph == 3);
          exp_o  = (ph == 0) ? port_d[p*8 +: 8] : (ph == 3) ? port_w[p*8 +: 8] : 8'h00;
          chk($sformatf("bus_p%0d_ph%0d", p, ph), 128'({bus_oe, bus_o}), 128'({exp_oe, exp_o}));
          if (m_cyc == 12) m_active = 1'b0;
        end else begin
          chk("idle_bus", 128'({bus_oe, bus_o}), 128'(0));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && pr9a) q9a.push_back(28);
    if (rst && pr9b) q9b.push_back(55);
  end

  always @(negedge clk) begin : mon9
    int e;
    if (!rst) begin
      c9a = 0;
      c9b = 0;
    end else begin
      if (sd9a) begin
        dn9a++;
        if (q9a.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty_t0: scan_done with no expected frame");
        end else begin
          e = q9a.pop_front();
          chk("len_t0", 128'(c9a + 1), 128'(e));
          chk("r_t0", 128'(r9a), 128'({9{8'h77}}));
        end
      end
      if (sd9b) begin
        dn9b++;
        if (q9b.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty_t3: scan_done with no expected frame");
        end else begin
          e = q9b.pop_front();
          chk("len_t3", 128'(c9b + 1), 128'(e));
          chk("r_t3", 128'(r9b), 128'({9{8'h77}}));
        end
      end
      c9a = pr9a ? 0 : c9a + 1;
      c9b = pr9b ? 0 : c9b + 1;
    end
  end

  initial begin
    bit idle_bad;
    rd_tab[0] = 24'hA5A5A5; chg_tab[0] = 3'b111;
    rd_tab[1] = 24'hA5A5A5; chg_tab[1] = 3'b111;
    rd_tab[2] = 24'hA5A55A; chg_tab[2] = 3'b101;
    rd_tab[3] = 24'h3CA55A; chg_tab[3] = 3'b100;
    rd_tab[4] = 24'h332211; chg_tab[4] = 3'b111;
    rd_tab[5] = 24'h332211; chg_tab[5] = 3'b111;
    port_d  = 24'hC30F81;
    port_w  = 24'h963C42;
    scan_en = 1'b0;
    en9     = 1'b0;
    rst     = 1'b1;
    #1 rst  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_port_r", 128'(port_r), 128'(0));
    chk("rst_chg", 128'(chg), 128'(0));
    chk("rst_scan_done", 128'(scan_done), 128'(0));
    chk("rst_port_rst", 128'(port_rst), 128'(0));
    chk("rst_bus_o", 128'(bus_o), 128'(0));
    chk("rst_bus_oe", 128'(bus_oe), 128'(0));
    rst     = 1'b1;
    scan_en = 1'b1;

    wait_cyc(3, 5, 200);
    scan_en = 1'b0;
    wait_done(4, 100);
    idle_bad = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (port_rst || bus_oe || scan_done) idle_bad = 1'b1;
    end
    chk("idle_quiet", 128'(idle_bad), 128'(0));

    scan_en = 1'b1;
    wait_cyc(4, 10, 100);
    rst = 1'b0;
    #1;
    chk("async_port_r", 128'(port_r), 128'(0));
    chk("async_chg", 128'(chg), 128'(0));
    chk("async_bus_o", 128'(bus_o), 128'(0));
    chk("async_bus_oe", 128'(bus_oe), 128'(0));
    chk("async_port_rst", 128'(port_rst), 128'(0));
    chk("async_scan_done", 128'(scan_done), 128'(0));
    exp_q.delete();
    @(negedge clk); #3;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("restart_sync", 128'({port_rst, bus_oe}), 128'(2'b10));
    wait_cyc(5, 5, 50);
    scan_en = 1'b0;
    wait_done(5, 100);

    en9 = 1'b1;
    for (int i = 0; i < 400 && (dn9a < 2 || dn9b < 2); i++) begin
      @(negedge clk); #1;
    end
    chk("t0_frames", 128'(dn9a >= 2), 128'(1));
    chk("t3_frames", 128'(dn9b >= 2), 128'(1));
    en9 = 1'b0;
    for (int i = 0; i < 200 && (q9a.size() != 0 || q9b.size() != 0); i++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 128'({exp_q.size(), q9a.size(), q9b.size()}), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
